// File: rtl/controller_pkg.sv
// Board-controller shared definitions: register map, header defaults,
// header checksum and the I2C slave FSM state encoding.
package controller_pkg;

  localparam logic [6:0] I2C_ADDR_DEF   = 7'h61;
  localparam logic [7:0] DEV_ID_MSB_DEF = 8'h20;
  localparam logic [7:0] DEV_ID_LSB_DEF = 8'h14;
  localparam logic [7:0] MAJ_VER_DEF    = 8'hF0;
  localparam logic [7:0] MIN_VER_DEF    = 8'h00;
  localparam logic [7:0] TEST_VER_DEF   = 8'h00;
  localparam logic [7:0] CPLD_REV_DEF   = 8'h16;

  localparam logic [7:0] REG_DEV_ID_MSB     = 8'h00;
  localparam logic [7:0] REG_DEV_ID_LSB     = 8'h01;
  localparam logic [7:0] REG_MAJ_VER        = 8'h02;
  localparam logic [7:0] REG_MIN_VER        = 8'h03;
  localparam logic [7:0] REG_TEST_VER       = 8'h04;
  localparam logic [7:0] REG_CHECKSUM       = 8'h05;
  localparam logic [7:0] REG_CPLD_REV       = 8'h06;
  localparam logic [7:0] REG_URT_INTERCONN  = 8'hA5;
  localparam logic [7:0] REG_URT_KEY_DIS    = 8'hA6;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_BYTE,
    ST_WR_ACK, ST_RD_BYTE, ST_RD_ACK, ST_WAIT_STOP
  } i2c_state_e;

  // Header checksum: the five header bytes plus this byte sum to 0 mod 256.
  function automatic logic [7:0] hdr_checksum(input logic [7:0] a, input logic [7:0] b,
                                               input logic [7:0] c, input logic [7:0] d,
                                               input logic [7:0] e);
    return 8'h00 - (a + b + c + d + e);
  endfunction

  localparam logic [7:0] CHECKSUM_DEF = hdr_checksum(DEV_ID_MSB_DEF, DEV_ID_LSB_DEF,
                                                     MAJ_VER_DEF, MIN_VER_DEF, TEST_VER_DEF);

endpackage

// File: rtl/controller_if.sv
// Register-access bus between the I2C slave engine (master side) and the
// register file (slave side). Writes are single-cycle strobes; reads are a
// combinational lookup of rd_addr.
interface controller_if;
  logic       wr_stb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  modport master (output wr_stb, output wr_addr, output wr_data, output rd_addr,
                  input  rd_data);
  modport slave  (input  wr_stb, input  wr_addr, input  wr_data, input  rd_addr,
                  output rd_data);
endinterface

// File: rtl/controller_i2c_slave_if.sv
// Bit-level I2C slave: input sync + majority filter, START/STOP detect,
// protocol FSM, shift register and auto-incrementing register pointer.
module i2c_slave_if import controller_pkg::*; #(
  parameter logic [6:0] I2C_ADDR = I2C_ADDR_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         scl,
  input  logic         sda_in,
  output logic         sda_oe,
  controller_if.master rbus
);

  logic [1:0] scl_sync, sda_sync;
  logic [2:0] scl_hist, sda_hist;
  logic       scl_f, sda_f, scl_d, sda_d;
  logic       scl_rise, scl_fall, start_det, stop_det;

  i2c_state_e state, state_nxt;
  logic [3:0] cnt;
  logic [7:0] shreg, ptr, wr_addr, wr_data;
  logic       first_byte, mack, wr_stb, addr_hit;
  logic [7:0] shreg_in;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Synchronize and glitch-filter the bus; idle-high reset avoids false edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11; sda_sync <= 2'b11;
      scl_hist <= 3'b111; sda_hist <= 3'b111;
      scl_f <= 1'b1; sda_f <= 1'b1; scl_d <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_in};
      scl_hist <= {scl_hist[1:0], scl_sync[1]};
      sda_hist <= {sda_hist[1:0], sda_sync[1]};
      scl_f    <= maj3(scl_hist);
      sda_f    <= maj3(sda_hist);
      scl_d    <= scl_f;
      sda_d    <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
  assign shreg_in  = {shreg[6:0], sda_f};
  assign addr_hit  = (shreg[7:1] == I2C_ADDR);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: START/STOP override everything; byte phases end on SCL fall.
  always_comb begin
    state_nxt = state;
    if (start_det)     state_nxt = ST_ADDR;
    else if (stop_det) state_nxt = ST_IDLE;
    else begin
      case (state)
        ST_ADDR:     if (scl_fall && cnt == 4'd8) state_nxt = addr_hit ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK: if (scl_fall) state_nxt = shreg[0] ? ST_RD_BYTE : ST_WR_BYTE;
        ST_WR_BYTE:  if (scl_fall && cnt == 4'd8) state_nxt = ST_WR_ACK;
        ST_WR_ACK:   if (scl_fall) state_nxt = ST_WR_BYTE;
        ST_RD_BYTE:  if (scl_fall && cnt == 4'd8) state_nxt = ST_RD_ACK;
        ST_RD_ACK:   if (scl_fall) state_nxt = mack ? ST_RD_BYTE : ST_WAIT_STOP;
        default:     ;
      endcase
    end
  end

  // Datapath: sample on SCL rise, change SDA only on detected SCL fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0; shreg <= '0; ptr <= '0; first_byte <= 1'b0; mack <= 1'b0;
      sda_oe <= 1'b0; wr_stb <= 1'b0; wr_addr <= '0; wr_data <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (start_det || stop_det) begin
        cnt    <= '0;
        sda_oe <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shreg <= shreg_in;
              cnt   <= cnt + 4'd1;
            end else if (scl_fall && cnt == 4'd8) sda_oe <= addr_hit;
          end
          ST_ADDR_ACK: if (scl_fall) begin
            cnt        <= '0;
            first_byte <= 1'b1;
            if (shreg[0]) begin
              shreg  <= rbus.rd_data;
              sda_oe <= ~rbus.rd_data[7];
            end else sda_oe <= 1'b0;
          end
          ST_WR_BYTE: begin
            if (scl_rise) begin
              shreg <= shreg_in;
              cnt   <= cnt + 4'd1;
              // Commit on the 8th rise; the first byte only sets the pointer.
              if (cnt == 4'd7) begin
                first_byte <= 1'b0;
                if (first_byte) ptr <= shreg_in;
                else begin
                  wr_stb  <= 1'b1;
                  wr_addr <= ptr;
                  wr_data <= shreg_in;
                  ptr     <= ptr + 8'd1;
                end
              end
            end else if (scl_fall && cnt == 4'd8) sda_oe <= 1'b1;
          end
          ST_WR_ACK: if (scl_fall) begin
            sda_oe <= 1'b0;
            cnt    <= '0;
          end
          ST_RD_BYTE: begin
            if (scl_rise) cnt <= cnt + 4'd1;
            else if (scl_fall) begin
              if (cnt == 4'd8) sda_oe <= 1'b0;
              else begin
                shreg  <= {shreg[6:0], 1'b0};
                sda_oe <= ~shreg[6];
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              mack <= ~sda_f;
              if (!sda_f) ptr <= ptr + 8'd1;
            end else if (scl_fall && mack) begin
              cnt    <= '0;
              shreg  <= rbus.rd_data;
              sda_oe <= ~rbus.rd_data[7];
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

  assign rbus.wr_stb  = wr_stb;
  assign rbus.wr_addr = wr_addr;
  assign rbus.wr_data = wr_data;
  assign rbus.rd_addr = ptr;

endmodule

// File: rtl/controller_top.sv
// Board-controller CPLD top: I2C slave engine, register file with read-only
// identity header, and the open-drain SDA pad.
module controller_top import controller_pkg::*; #(
  parameter logic [6:0] I2C_ADDR   = I2C_ADDR_DEF,
  parameter logic [7:0] DEV_ID_MSB = DEV_ID_MSB_DEF,
  parameter logic [7:0] DEV_ID_LSB = DEV_ID_LSB_DEF,
  parameter logic [7:0] MAJ_VER    = MAJ_VER_DEF,
  parameter logic [7:0] MIN_VER    = MIN_VER_DEF,
  parameter logic [7:0] TEST_VER   = TEST_VER_DEF,
  parameter logic [7:0] CPLD_REV   = CPLD_REV_DEF
) (
  input  logic SYSCLK,
  input  logic RESET_N,
  input  logic SCL,
  inout  wire  SDA
);

  localparam logic [7:0] CHECKSUM = hdr_checksum(DEV_ID_MSB, DEV_ID_LSB, MAJ_VER, MIN_VER, TEST_VER);

  controller_if rbus ();
  logic       sda_oe;
  logic [7:0] reg_urt_interconn, reg_urt_key_dis;

  i2c_slave_if #(.I2C_ADDR(I2C_ADDR)) u_slave (
    .clk    (SYSCLK),
    .rst_n  (RESET_N),
    .scl    (SCL),
    .sda_in (SDA),
    .sda_oe (sda_oe),
    .rbus   (rbus)
  );

  // Writable registers; writes to any other address are dropped.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      reg_urt_interconn <= 8'h00;
      reg_urt_key_dis   <= 8'h00;
    end else if (rbus.wr_stb) begin
      case (rbus.wr_addr)
        REG_URT_INTERCONN: reg_urt_interconn <= rbus.wr_data;
        REG_URT_KEY_DIS:   reg_urt_key_dis   <= rbus.wr_data;
        default:           ;
      endcase
    end
  end

  // Read mux; unmapped addresses read zero.
  always_comb begin
    rbus.rd_data = 8'h00;
    case (rbus.rd_addr)
      REG_DEV_ID_MSB:    rbus.rd_data = DEV_ID_MSB;
      REG_DEV_ID_LSB:    rbus.rd_data = DEV_ID_LSB;
      REG_MAJ_VER:       rbus.rd_data = MAJ_VER;
      REG_MIN_VER:       rbus.rd_data = MIN_VER;
      REG_TEST_VER:      rbus.rd_data = TEST_VER;
      REG_CHECKSUM:      rbus.rd_data = CHECKSUM;
      REG_CPLD_REV:      rbus.rd_data = CPLD_REV;
      REG_URT_INTERCONN: rbus.rd_data = reg_urt_interconn;
      REG_URT_KEY_DIS:   rbus.rd_data = reg_urt_key_dis;
      default:           ;
    endcase
  end

  // Open-drain pad: pull low or release, never drive high.
  assign SDA = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_controller_top.sv
// Bench for controller_top: bit-banged I2C master, register-map reference
// model, and a scoreboard fed by stimulus (expected) and bus samples (actual).
module tb_controller_top;

  localparam int         Q    = 6;       // SYSCLK cycles per quarter SCL period
  localparam logic [6:0] ADDR = 7'h61;

  logic clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m_oe = 1'b0;
  wire  sda_w;

  assign sda_w = sda_m_oe ? 1'b0 : 1'bz;
  pullup (sda_w);

  always #20 clk = ~clk;

  controller_top dut (.SYSCLK(clk), .RESET_N(rst_n), .SCL(scl_m), .SDA(sda_w));

  typedef struct { string name; logic [7:0] val; } item_t;
  item_t exp_q[$];
  item_t act_q[$];
  int n_tests = 0, n_fail = 0;

  // Reference model state.
  logic [7:0] m_ptr = 8'h00, m_a5 = 8'h00, m_a6 = 8'h00;

  function automatic logic [7:0] model_rd(input logic [7:0] a);
    int sum;
    sum = 'h20 + 'h14 + 'hF0 + 'h00 + 'h00;
    case (a)
      8'h00: return 8'h20;
      8'h01: return 8'h14;
      8'h02: return 8'hF0;
      8'h05: return 8'((256 - (sum % 256)) % 256);
      8'h06: return 8'h16;
      8'hA5: return m_a5;
      8'hA6: return m_a6;
      default: return 8'h00;
    endcase
  endfunction

  function automatic void model_wr(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'hA5) m_a5 = d;
    if (a == 8'hA6) m_a6 = d;
  endfunction

  function automatic void model_reset();
    m_ptr = 8'h00; m_a5 = 8'h00; m_a6 = 8'h00;
  endfunction

  function automatic void expect_v(input string n, input logic [7:0] v);
    item_t it;
    it.name = n; it.val = v;
    exp_q.push_back(it);
  endfunction

  function automatic void observe(input string n, input logic [7:0] v);
    item_t it;
    it.name = n; it.val = v;
    act_q.push_back(it);
  endfunction

  function automatic logic [7:0] line_val();
    return (sda_w === 1'b0) ? 8'd0 : 8'd1;
  endfunction

  // Scoreboard monitor: pairs each observed value with the oldest expectation.
  initial begin : monitor
    item_t a, e;
    forever begin
      @(negedge clk);
      while (act_q.size() > 0) begin
        a = act_q.pop_front();
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s: got %0h, nothing expected", a.name, a.val);
        end else begin
          e = exp_q.pop_front();
          if (e.name != a.name || e.val !== a.val) begin
            n_fail++;
            $display("FAIL %s: got %s=%0h, required %0h", e.name, a.name, a.val, e.val);
          end
        end
      end
    end
  end

  // ---------------- bus master ----------------
  task automatic qd();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic clk_bit(input logic b, output logic s);
    qd(); sda_m_oe = ~b;
    qd(); scl_m = 1'b1;
    qd(); s = (sda_w === 1'b0) ? 1'b0 : 1'b1;
    qd(); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    qd(); sda_m_oe = 1'b0;
    qd(); scl_m = 1'b1;
    qd(); sda_m_oe = 1'b1;
    qd(); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    qd(); sda_m_oe = 1'b1;
    qd(); scl_m = 1'b1;
    qd(); sda_m_oe = 1'b0;
    qd();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic [8:0] b9;
    logic s;
    b9 = {b, 1'b1};
    for (int i = 8; i >= 0; i--) clk_bit(b9[i], s);
    ack = s;
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(master_ack ? 1'b0 : 1'b1, s);
  endtask

  // ---------------- transactions ----------------
  task automatic tx_addr(input logic [6:0] a, input logic rw);
    logic ack;
    expect_v("addr_ack", (a == ADDR) ? 8'd0 : 8'd1);
    send_byte({a, rw}, ack);
    observe("addr_ack", {7'd0, ack});
  endtask

  task automatic do_read(input int n);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      expect_v("rd_data", model_rd(m_ptr));
      recv_byte(i < n - 1, d);
      observe("rd_data", d);
      if (i < n - 1) m_ptr = m_ptr + 8'd1;
    end
    expect_v("sda_rel", 8'd1);
    qd();
    observe("sda_rel", line_val());
  endtask

  task automatic tx_write(input logic [6:0] a, input logic [7:0] p, input int n,
                          input logic [3:0][7:0] d);
    logic ack;
    i2c_start();
    tx_addr(a, 1'b0);
    if (a == ADDR) begin
      expect_v("ptr_ack", 8'd0);
      send_byte(p, ack);
      observe("ptr_ack", {7'd0, ack});
      m_ptr = p;
      for (int i = 0; i < n; i++) begin
        expect_v("wr_ack", 8'd0);
        send_byte(d[i], ack);
        observe("wr_ack", {7'd0, ack});
        model_wr(m_ptr, d[i]);
        m_ptr = m_ptr + 8'd1;
      end
    end
    i2c_stop();
  endtask

  task automatic tx_read(input logic [6:0] a, input int n);
    i2c_start();
    tx_addr(a, 1'b1);
    if (a == ADDR) do_read(n);
    i2c_stop();
  endtask

  task automatic tx_ptr_read(input logic [7:0] p, input int n, input logic rep);
    logic ack;
    i2c_start();
    tx_addr(ADDR, 1'b0);
    expect_v("ptr_ack", 8'd0);
    send_byte(p, ack);
    observe("ptr_ack", {7'd0, ack});
    m_ptr = p;
    if (!rep) i2c_stop();
    i2c_start();
    tx_addr(ADDR, 1'b1);
    do_read(n);
    i2c_stop();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    qd();
    expect_v("rst_sda", 8'd1);
    observe("rst_sda", line_val());
    model_reset();
    rst_n = 1'b1;
    qd();
  endtask

  function automatic logic [7:0] pick_ptr();
    case ($urandom_range(0, 5))
      0:       return 8'($urandom_range(0, 6));
      1:       return 8'hA5;
      2:       return 8'hA6;
      3:       return 8'(8'hA4 + $urandom_range(0, 3));
      4:       return 8'(8'hFE + $urandom_range(0, 1));
      default: return 8'($urandom);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin : stim
    logic       s;
    logic [6:0] wa;
    logic [7:0] p;
    int         n;
    logic [31:0] data;

    qd();
    expect_v("rst_sda", 8'd1);
    observe("rst_sda", line_val());
    rst_n = 1'b1;
    qd();
    expect_v("idle_sda", 8'd1);
    observe("idle_sda", line_val());

    // Header registers one at a time.
    for (int r = 0; r <= 5; r++) tx_ptr_read(8'(r), 1, 1'b0);

    // Wrong address: NACK, nothing written.
    tx_write(7'h62, 8'hA5, 1, 32'h0000_0077);
    tx_ptr_read(8'hA5, 1, 1'b0);

    // Pointer then data, read back.
    tx_write(ADDR, 8'hA5, 1, 32'h0000_0055);
    tx_ptr_read(8'hA5, 1, 1'b0);

    // Burst across checksum and revision, ACK then NACK.
    tx_ptr_read(8'h05, 2, 1'b0);

    // Key-disable register survives until reset.
    tx_write(ADDR, 8'hA6, 1, 32'h0000_003C);
    tx_ptr_read(8'hA6, 1, 1'b0);
    pulse_reset();
    tx_ptr_read(8'hA6, 1, 1'b0);
    tx_write(ADDR, 8'h02, 1, 32'h0000_0099);
    tx_ptr_read(8'h02, 1, 1'b0);

    // Repeated start and pointer wrap.
    tx_ptr_read(8'h01, 1, 1'b1);
    tx_ptr_read(8'hFF, 2, 1'b1);

    // Two-byte write spanning both writable registers.
    tx_write(ADDR, 8'hA5, 2, 32'h0000_B2A1);
    tx_ptr_read(8'hA5, 2, 1'b1);

    // Reset while the slave is driving a read byte.
    i2c_start();
    tx_addr(ADDR, 1'b1);
    clk_bit(1'b1, s);
    rst_n = 1'b0;
    qd();
    expect_v("rst_mid_sda", 8'd1);
    observe("rst_mid_sda", line_val());
    model_reset();
    scl_m = 1'b1;
    sda_m_oe = 1'b0;
    qd();
    rst_n = 1'b1;
    qd();
    // Bus traffic without a START must be ignored.
    scl_m = 1'b0;
    qd();
    expect_v("no_start_ack", 8'd1);
    send_byte({ADDR, 1'b0}, s);
    observe("no_start_ack", {7'd0, s});
    i2c_stop();
    tx_ptr_read(8'h06, 1, 1'b0);

    // Randomized traffic against the model.
    for (int it = 0; it < 20; it++) begin
      n    = $urandom_range(1, 3);
      data = $urandom;
      case ($urandom_range(0, 4))
        0: tx_write(ADDR, pick_ptr(), n, data);
        1: tx_read(ADDR, n);
        2: tx_ptr_read(pick_ptr(), n, 1'($urandom_range(0, 1)));
        3: begin
          wa = 7'($urandom);
          if (wa == ADDR) wa = wa ^ 7'h01;
          if ($urandom_range(0, 1) == 1) tx_write(wa, pick_ptr(), n, data);
          else tx_read(wa, n);
        end
        default: begin
          p = pick_ptr();
          tx_write(ADDR, p, n, data);
          tx_ptr_read(p, n, 1'b1);
        end
      endcase
    end

    repeat (10) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected items never observed, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
